// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiply unit: FSM states,
// default operand width and the iteration-counter width helper.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_sequencer_if.sv
// Start/busy/done request channel between the EX stage (master) and the
// multiply unit (slave).
interface mul_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic                 start;
    logic                 signed_op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_op, a, b, flush,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_op, a, b, flush,
        output busy, done, product
    );
endinterface

// File: rtl/mul_datapath.sv
// Shift-add datapath: operand magnitudes, partial-product register P,
// (W+1)-bit accumulate adder and the sign-corrected product register.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic                 signed_op,
    input  logic                 neg,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product
);

    // The most-negative value negates to itself, which read unsigned is 2^(W-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    logic [WIDTH-1:0]   mcand_d, mcand_q;
    logic [2*WIDTH-1:0] p_d, p_q;
    logic [2*WIDTH-1:0] product_d, product_q;
    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;

    // Next-state for multiplicand, partial product and result
    always_comb begin
        mcand_d   = mcand_q;
        p_d       = p_q;
        product_d = product_q;
        addend_s  = p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
        sum_s     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + addend_s;
        if (load) begin
            mcand_d = magnitude(a, signed_op);
            p_d     = {{WIDTH{1'b0}}, magnitude(b, signed_op)};
        end else if (step) begin
            // {carry, upper half} after the add, shifted right as one 2W+1 word
            p_d = {sum_s, p_q[WIDTH-1:1]};
        end else begin
            p_d = p_q;
        end
        if (fix) begin
            product_d = neg ? ((~p_q) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_q;
        end else begin
            product_d = product_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= {WIDTH{1'b0}};
            p_q       <= {(2*WIDTH){1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply control: FSM, iteration counter, result sign and
// the registered busy/done handshake towards the pipeline.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    mul_sequencer_if.slave  bus
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    state_e          state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic            neg_d, neg_q;
    logic            busy_q, done_q;
    logic            load_s, step_s, fix_s;

    // Next-state and datapath strobes; flush aborts from any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        fix_s   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        load_s  = 1'b1;
                        neg_d   = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        cnt_d   = {CW{1'b0}};
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    step_s = 1'b1;
                    cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIX;
                    end else begin
                        state_d = RUN;
                    end
                end
                FIX: begin
                    fix_s   = 1'b1;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers; handshake outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    mul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .fix       (fix_s),
        .signed_op (bus.signed_op),
        .neg       (neg_d),
        .a         (bus.a),
        .b         (bus.b),
        .product   (bus.product)
    );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: stimulus pushes expected products and
// done cycles into a queue, a negedge monitor pops and compares on done.
module tb_mul_sequencer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    typedef struct {
        logic [31:0] prod;
        int          at;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: product 0x%08h, no operation pending",
                         cyc, bus.product);
            end else begin
                e = sbq.pop_front();
                check("product", bus.product, e.prod);
                check("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start in cycle c0; returns in cycle c0+1
    task automatic issue(input logic sgn, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [31:0] exp, input bit push, output int c0);
        tick();
        c0            = cyc;
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.a         = aa;
        bus.b         = bb;
        if (push) sbq.push_back('{exp, c0 + W + 2});
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL wait_idle: busy still 1 after 60 cycles, required 0");
        end
        check("queue_drained", 32'(sbq.size()), 32'd0);
    endtask

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[6] = '{
        '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1},
        '{1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000},
        '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001},
        '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000},
        '{1'b1, 16'h0000, 16'hFFFF, 32'h0000_0000},
        '{1'b0, 16'h0000, 16'hFFFF, 32'h0000_0000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.flush     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_product", bus.product, 32'd0);

        // Unsigned 3*5 with cycle-exact busy/done profile
        issue(1'b0, 16'd3, 16'd5, 32'h0000_000F, 1'b1, c0);
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), {31'd0, bus.busy}, (k <= W + 2) ? 32'd1 : 32'd0);
            check($sformatf("done_c%0d", k), {31'd0, bus.done}, (k == W + 2) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].p, 1'b1, c0);
            wait_idle();
        end

        // Start pulse in cycle 5 of an operation is ignored
        issue(1'b0, 16'd7, 16'd9, 32'h0000_003F, 1'b1, c0);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.a     = 16'd2;
        bus.b     = 16'd2;
        tick();
        bus.start = 1'b0;
        wait_idle();
        repeat (25) tick();

        // Start held high: second op accepted in the first IDLE cycle after DONE
        tick();
        c0            = cyc;
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.a         = 16'd3;
        bus.b         = 16'd5;
        sbq.push_back('{32'h0000_000F, c0 + W + 2});
        sbq.push_back('{32'h0000_002A, c0 + 2 * W + 5});
        repeat (2) tick();
        bus.a = 16'd6;
        bus.b = 16'd7;
        repeat (18) tick();
        bus.start = 1'b0;
        wait_idle();

        // Flush mid-operation after a prior 0x1234 result
        issue(1'b0, 16'h1234, 16'h0001, 32'h0000_1234, 1'b1, c0);
        wait_idle();
        issue(1'b0, 16'd3, 16'd5, 32'h0, 1'b0, c0);
        repeat (7) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_product", bus.product, 32'h0000_1234);
        repeat (25) tick();
        check("flush_product_held", bus.product, 32'h0000_1234);
        issue(1'b0, 16'd2, 16'd2, 32'h0000_0004, 1'b1, c0);
        wait_idle();

        // Reset in cycle 10 of an operation
        issue(1'b0, 16'd3, 16'd5, 32'h0, 1'b0, c0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", bus.product, 32'd0);
        issue(1'b0, 16'd5, 16'd5, 32'h0000_0019, 1'b1, c0);
        wait_idle();

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
